// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo -- single-clock synchronous FIFO with registered read data
//
// Parameters
//   DATA_WIDTH : width of one stored word in bits (default 8)
//   DEPTH      : capacity in words, power of two, at least 2 (default 16)
//
// Ports
//   clk       : single clock, every state change on its rising edge
//   reset     : synchronous active-high reset, takes priority over accesses
//   data_in   : write data, stored when a write is accepted
//   en_write  : write request
//   en_read   : read request
//   data_out  : registered read data, loaded one edge after an accepted read
//               request and held while no read is accepted
//   overflow  : raised after a write was rejected because the FIFO was full
//   underflow : raised after a read was rejected because the FIFO was empty
//   full      : count equals DEPTH (combinational from state)
//   empty     : count equals zero (combinational from state)
//   count     : number of words currently stored
//
// Configuration macro
//   FIFO_STICKY_FLAGS_EN : when defined, overflow and underflow latch at 1
//                          after the first violation and clear only on
//                          reset. When undefined they are one-cycle pulses.
// ---------------------------------------------------------------------------
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     en_write,
  input  logic                     en_read,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic accept_write;
  logic accept_read;
  logic overflow_hit;
  logic underflow_hit;

  // Status flags come straight from the stored-word count so they are
  // always consistent with it, without extra registers to keep in step.
  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);

  // A read is accepted whenever something is stored. A write is accepted
  // when there is room, or when the FIFO is full but a read frees a slot
  // on the same edge. Since DEPTH >= 2, full implies not empty, so a
  // simultaneous read/write on a full FIFO always succeeds. On an empty
  // FIFO the read is rejected and the write still goes in; data_in is
  // never forwarded to data_out.
  assign accept_read   = en_read && !empty;
  assign accept_write  = en_write && (!full || accept_read);
  assign overflow_hit  = en_write && !accept_write;
  assign underflow_hit = en_read && !accept_read;

  // Storage array. It has no reset on purpose: after a reset the pointers
  // restart at zero, so any old contents are unreachable until they are
  // overwritten. Writes are suppressed on a reset edge so reset has
  // priority over a simultaneous write request.
  always_ff @(posedge clk) begin
    if (!reset && accept_write) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, count and registered read data. Pointers are exactly
  // ADDR_WIDTH bits wide, so they wrap from DEPTH-1 back to 0 naturally.
  // The count changes only when exactly one side of the transfer is
  // accepted; a simultaneous accepted read and write leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (accept_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (accept_read) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= mem[rd_ptr];
      end
      case ({accept_write, accept_read})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Error flags. In the default build each flag reflects only the
  // violation seen at the most recent edge, giving a one-cycle pulse.
  // With sticky flags enabled a flag, once set, stays set until reset so
  // that slow software polling cannot miss a violation.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_FLAGS_EN
      overflow  <= overflow  | overflow_hit;
      underflow <= underflow | underflow_hit;
`else
      overflow  <= overflow_hit;
      underflow <= underflow_hit;
`endif
    end
  end

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo -- self-checking bench for fifo (DATA_WIDTH=8, DEPTH=16)
//
// A queue-based reference model follows the FIFO's behaviour from the
// request/acceptance rules; a compare process checks every DUT output
// against it on each falling edge once the first reset has happened.
// Directed sequences add hand-computed literal expectations, then a long
// randomized phase with varying read/write bias and occasional resets runs.
// Honours FIFO_STICKY_FLAGS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          en_write;
  logic          en_read;
  logic [DW-1:0] data_out;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] model_dout;
  logic          model_ovf;
  logic          model_unf;
  logic          model_valid = 1'b0;

  logic [DW-1:0] written [15];

  fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .en_write  (en_write),
    .en_read   (en_read),
    .data_out  (data_out),
    .overflow  (overflow),
    .underflow (underflow),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports it when the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs just after a falling edge, then returns
  // shortly after the following rising edge so results can be sampled.
  task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                               input logic [DW-1:0] din);
    @(negedge clk);
    reset    = rst;
    en_write = wr;
    en_read  = rd;
    data_in  = din;
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the FIFO must hold after each rising edge.
  // A read succeeds if anything is stored; a write succeeds if there is
  // room or a read frees a slot in the same cycle. Popping before pushing
  // makes the empty-FIFO read+write case reject the read naturally.
  always @(posedge clk) begin
    logic rd_ok;
    logic wr_ok;
    if (reset) begin
      model_q.delete();
      model_dout  = '0;
      model_ovf   = 1'b0;
      model_unf   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      rd_ok = en_read && (model_q.size() > 0);
      wr_ok = en_write && ((model_q.size() < DEPTH) || rd_ok);
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(data_in);
`ifdef FIFO_STICKY_FLAGS_EN
      model_ovf = model_ovf | (en_write && !wr_ok);
      model_unf = model_unf | (en_read && !rd_ok);
`else
      model_ovf = en_write && !wr_ok;
      model_unf = en_read && !rd_ok;
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("cyc_data_out",  32'(data_out),  32'(model_dout));
      checkOutput("cyc_count",     32'(count),     32'(model_q.size()));
      checkOutput("cyc_full",      32'(full),      32'(model_q.size() == DEPTH));
      checkOutput("cyc_empty",     32'(empty),     32'(model_q.size() == 0));
      checkOutput("cyc_overflow",  32'(overflow),  32'(model_ovf));
      checkOutput("cyc_underflow", 32'(underflow), 32'(model_unf));
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    int pw;
    int pr;
    reset    = 1'b1;
    en_write = 1'b0;
    en_read  = 1'b0;
    data_in  = '0;
    pw       = 50;
    pr       = 50;

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("rst_count",     32'(count),     32'd0);
    checkOutput("rst_empty",     32'(empty),     32'd1);
    checkOutput("rst_full",      32'(full),      32'd0);
    checkOutput("rst_data_out",  32'(data_out),  32'd0);
    checkOutput("rst_overflow",  32'(overflow),  32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);

    $display("[TB] fifteen random writes");
    for (int i = 0; i < 15; i++) begin
      written[i] = DW'($urandom);
      applyStimulus(1'b0, 1'b1, 1'b0, written[i]);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("w15_count",       32'(count),          32'd15);
    checkOutput("w15_model_count", 32'(model_q.size()), 32'd15);
    checkOutput("w15_full",        32'(full),           32'd0);
    checkOutput("w15_empty",       32'(empty),          32'd0);
    checkOutput("w15_overflow",    32'(overflow),       32'd0);

    $display("[TB] sixteen reads, last one from empty");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      checkOutput("r15_data_out", 32'(data_out), 32'(written[i]));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("r16_data_hold", 32'(data_out),  32'(written[14]));
    checkOutput("r16_underflow", 32'(underflow), 32'd1);
    checkOutput("r16_empty",     32'(empty),     32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
`ifdef FIFO_STICKY_FLAGS_EN
    checkOutput("r16_unf_sticky", 32'(underflow), 32'd1);
`else
    checkOutput("r16_unf_pulse_end", 32'(underflow), 32'd0);
`endif

    $display("[TB] seventeen writes 0x01..0x11");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int v = 1; v <= 17; v++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, DW'(v));
      if (v == 15) checkOutput("w17_not_full_yet", 32'(full), 32'd0);
      if (v == 16) checkOutput("w17_full",         32'(full), 32'd1);
    end
    checkOutput("w17_overflow", 32'(overflow), 32'd1);
    checkOutput("w17_count",    32'(count),    32'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
`ifndef FIFO_STICKY_FLAGS_EN
    checkOutput("w17_ovf_pulse_end", 32'(overflow), 32'd0);
`endif

    $display("[TB] read+write while full");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hAA);
    checkOutput("fullrw_data_out", 32'(data_out), 32'h01);
    checkOutput("fullrw_count",    32'(count),    32'd16);
    checkOutput("fullrw_full",     32'(full),     32'd1);
`ifndef FIFO_STICKY_FLAGS_EN
    checkOutput("fullrw_overflow", 32'(overflow), 32'd0);
`endif
    for (int v = 2; v <= 16; v++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      checkOutput("drain_data_out", 32'(data_out), 32'(v));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("drain_last_aa", 32'(data_out), 32'hAA);
    checkOutput("drain_empty",   32'(empty),    32'd1);

    $display("[TB] reset with five words stored");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, DW'(8'h30 + v));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("pre_rst_data_out", 32'(data_out), 32'h30);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
    checkOutput("midrst_count",    32'(count),    32'd0);
    checkOutput("midrst_empty",    32'(empty),    32'd1);
    checkOutput("midrst_data_out", 32'(data_out), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("midrst_underflow", 32'(underflow), 32'd1);
    checkOutput("midrst_data_hold", 32'(data_out),  32'd0);
`ifdef FIFO_STICKY_FLAGS_EN
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("sticky_underflow", 32'(underflow), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("sticky_cleared", 32'(underflow), 32'd0);
`else
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("midrst_unf_pulse_end", 32'(underflow), 32'd0);
`endif

    $display("[TB] empty FIFO read+write");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
    checkOutput("emptyrw_count",     32'(count),     32'd1);
    checkOutput("emptyrw_underflow", 32'(underflow), 32'd1);
    checkOutput("emptyrw_data_out",  32'(data_out),  32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        pw = int'($urandom_range(15, 90));
        pr = int'($urandom_range(15, 90));
      end
      applyStimulus($urandom_range(0, 199) == 0,
                    int'($urandom_range(0, 99)) < pw,
                    int'($urandom_range(0, 99)) < pr,
                    DW'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, storage capacity in words, power of two, minimum 2.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The module SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-006 The module SHALL have port en_write, input, 1 bit: write request.
REQ-007 The module SHALL have port en_read, input, 1 bit: read request.
REQ-008 The module SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-009 The module SHALL have port overflow, output, 1 bit: write attempted while full.
REQ-010 The module SHALL have port underflow, output, 1 bit: read attempted while empty.
REQ-011 The module SHALL have port full, output, 1 bit: count equals DEPTH, combinational from state.
REQ-012 The module SHALL have port empty, output, 1 bit: count equals 0, combinational from state.
REQ-013 The module SHALL have port count, output, log2(DEPTH)+1 bits: number of stored words.

Function
REQ-014 Storage SHALL be a DEPTH-entry array with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 Accepted write: en_write=1 and not full -> data_in stored at the write pointer, pointer +1, at the same edge.
REQ-016 Accepted read: en_read=1 and not empty -> word at the read pointer loaded into data_out at that edge (1-cycle latency), pointer +1.
REQ-017 data_out SHALL hold its last value when no read is accepted.
REQ-018 Simultaneous en_read and en_write while neither full nor empty -> both accepted, count unchanged.
REQ-019 Simultaneous en_read and en_write while full -> read and write both accepted, count stays DEPTH, overflow not raised.
REQ-020 Simultaneous en_read and en_write while empty -> write accepted, read rejected, underflow raised, no bypass of data_in to data_out.
REQ-021 Rejected write (full, no simultaneous read) -> memory, pointer and count unchanged; overflow=1 in the following cycle.
REQ-022 Rejected read (empty) -> data_out, pointer and count unchanged; underflow=1 in the following cycle.
REQ-023 Without the configuration macro, overflow and underflow SHALL be single-cycle pulses, cleared on the next edge that has no new violation.
REQ-024 count SHALL be incremented on accepted write only, decremented on accepted read only, and never exceed DEPTH or go below 0.

Reset
REQ-025 reset=1 at a rising edge SHALL clear both pointers, count, data_out, overflow and underflow to 0, so that empty=1 and full=0.
REQ-026 Reset SHALL take priority over simultaneous en_read or en_write; no access occurs on the reset edge.
REQ-027 Reset SHALL not clear memory contents; stale words are unreachable because the pointers restart at 0.
REQ-028 Reset asserted mid-operation SHALL discard all stored words.

Configuration
REQ-029 Macro FIFO_STICKY_FLAGS_EN defined -> overflow and underflow SHALL latch at 1 after the first violation and clear only on reset.
REQ-030 Macro FIFO_STICKY_FLAGS_EN undefined -> overflow and underflow SHALL behave as the pulses of REQ-023.

Verification
REQ-031 Reset, then 15 writes of random bytes, then idle -> count=15, full=0, empty=0, overflow=0.
REQ-032 After REQ-031, en_read held high for 16 cycles -> data_out returns the 15 bytes in write order, one per cycle. The 16th read returns no new data, data_out holds the last byte, underflow pulses, and empty=1.
REQ-033 17 writes of 0x01..0x11 from empty -> full=1 after the 16th write; 17th write rejected with an overflow pulse; the reads that follow return 0x01..0x10.
REQ-034 Full FIFO with en_read=1, en_write=1 and data_in=0xAA for one cycle -> oldest word appears on data_out, count stays 16, and 0xAA is read out last.
REQ-035 Reset asserted with 5 words stored -> next cycle count=0, empty=1, data_out=0x00; a following read gives an underflow pulse.
REQ-036 With FIFO_STICKY_FLAGS_EN defined, one read from empty -> underflow stays 1 for every subsequent cycle until reset.
